// File: rtl/kbd_pkg.sv
// Shared constants, FSM state type and ASCII translation for the PS/2 set-2 key decoder.
package kbd_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StBrk    = 2'd1,
    StExt    = 2'd2,
    StExtBrk = 2'd3
  } kbd_state_e;

  localparam int unsigned EntryW = 16;

  localparam logic [7:0] ScanExt    = 8'hE0;
  localparam logic [7:0] ScanBreak  = 8'hF0;
  localparam logic [7:0] ScanAck    = 8'hFA;
  localparam logic [7:0] ScanBat    = 8'hAA;
  localparam logic [7:0] ScanPause  = 8'hE1;
  localparam logic [7:0] ScanLShift = 8'h12;
  localparam logic [7:0] ScanRShift = 8'h59;
  localparam logic [7:0] ScanCaps   = 8'h58;

  // Letters resolve to lowercase first; uppercase is a fixed 0x20 offset.
  function automatic logic [7:0] scan_to_ascii(input logic [7:0] code, input logic upper);
    logic [7:0] ch;
    logic       letter;
    ch     = 8'h00;
    letter = 1'b1;
    case (code)
      8'h1C: ch = 8'h61;
      8'h32: ch = 8'h62;
      8'h21: ch = 8'h63;
      8'h23: ch = 8'h64;
      8'h24: ch = 8'h65;
      8'h2B: ch = 8'h66;
      8'h34: ch = 8'h67;
      8'h33: ch = 8'h68;
      8'h43: ch = 8'h69;
      8'h3B: ch = 8'h6A;
      8'h42: ch = 8'h6B;
      8'h4B: ch = 8'h6C;
      8'h3A: ch = 8'h6D;
      8'h31: ch = 8'h6E;
      8'h44: ch = 8'h6F;
      8'h4D: ch = 8'h70;
      8'h15: ch = 8'h71;
      8'h2D: ch = 8'h72;
      8'h1B: ch = 8'h73;
      8'h2C: ch = 8'h74;
      8'h3C: ch = 8'h75;
      8'h2A: ch = 8'h76;
      8'h1D: ch = 8'h77;
      8'h22: ch = 8'h78;
      8'h35: ch = 8'h79;
      8'h1A: ch = 8'h7A;
      default: letter = 1'b0;
    endcase
    if (!letter) begin
      case (code)
        8'h45:   ch = 8'h30;
        8'h16:   ch = 8'h31;
        8'h1E:   ch = 8'h32;
        8'h26:   ch = 8'h33;
        8'h25:   ch = 8'h34;
        8'h2E:   ch = 8'h35;
        8'h36:   ch = 8'h36;
        8'h3D:   ch = 8'h37;
        8'h3E:   ch = 8'h38;
        8'h46:   ch = 8'h39;
        8'h29:   ch = 8'h20;
        8'h5A:   ch = 8'h0D;
        8'h66:   ch = 8'h08;
        default: ch = 8'h00;
      endcase
    end
    if (letter && upper) begin
      ch = ch - 8'h20;
    end
    return ch;
  endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Small synchronous FIFO; a push into a full queue is accepted only alongside a pop.
module kbd_fifo
  import kbd_pkg::*;
#(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = EntryW
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic             accept_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);

  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [AddrW:0] FullCount = (AddrW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   count_q;
  logic             do_pop;

  assign empty_o  = (count_q == '0);
  assign full_o   = (count_q == FullCount);
  assign do_pop   = pop_i & ~empty_o;
  assign accept_o = push_i & (~full_o | do_pop);
  assign head_o   = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (accept_o) begin
        wr_ptr_q <= wr_ptr_q + AddrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AddrW'(1);
      end
      case ({accept_o, do_pop})
        2'b10:   count_q <= count_q + (AddrW + 1)'(1);
        2'b01:   count_q <= count_q - (AddrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk_i) begin
    if (accept_o) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/kbd_decoder.sv
// PS/2 set-2 decoder: prefix FSM, modifier tracking, typematic suppression and an event queue.
module kbd_decoder
  import kbd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scan_valid,
  input  logic [7:0]       scan_code,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [7:0]       ev_scan,
  output logic [7:0]       ev_ascii,
  output logic             shift_o,
  output logic             caps_o,
  output logic [CNT_W-1:0] press_cnt,
  output logic             overflow
);

  kbd_state_e       state_q, state_d;
  logic [7:0]       held_q, held_d;
  logic             lshift_q, lshift_d;
  logic             rshift_q, rshift_d;
  logic             caps_q, caps_d;
  logic [CNT_W-1:0] cnt_q;
  logic             overflow_q;

  logic              push;
  logic [EntryW-1:0] push_data;
  logic              accept;
  logic              fifo_full;
  logic              fifo_empty;
  logic [EntryW-1:0] head;
  logic              ignored;

  assign shift_o   = lshift_q | rshift_q;
  assign caps_o    = caps_q;
  assign press_cnt = cnt_q;
  assign overflow  = overflow_q;
  assign ev_valid  = ~fifo_empty;
  assign ev_scan   = head[15:8];
  assign ev_ascii  = head[7:0];
  assign ignored   = (scan_code == ScanAck) || (scan_code == ScanBat) || (scan_code == ScanPause);

  always_comb begin
    state_d   = state_q;
    held_d    = held_q;
    lshift_d  = lshift_q;
    rshift_d  = rshift_q;
    caps_d    = caps_q;
    push      = 1'b0;
    // Case is taken from modifier state before this byte is applied.
    push_data = {scan_code, scan_to_ascii(scan_code, shift_o ^ caps_q)};
    if (scan_valid) begin
      case (state_q)
        StIdle: begin
          if (scan_code == ScanBreak) begin
            state_d = StBrk;
          end else if (scan_code == ScanExt) begin
            state_d = StExt;
          end else if (!ignored && (scan_code != held_q)) begin
            held_d = scan_code;
            if (scan_code == ScanLShift) begin
              lshift_d = 1'b1;
            end else if (scan_code == ScanRShift) begin
              rshift_d = 1'b1;
            end else if (scan_code == ScanCaps) begin
              caps_d = ~caps_q;
            end else begin
              push = 1'b1;
            end
          end
        end
        StBrk: begin
          state_d = StIdle;
          if (scan_code == ScanLShift) begin
            lshift_d = 1'b0;
          end
          if (scan_code == ScanRShift) begin
            rshift_d = 1'b0;
          end
          if (scan_code == held_q) begin
            held_d = 8'h00;
          end
        end
        StExt: begin
          state_d = (scan_code == ScanBreak) ? StExtBrk : StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      held_q     <= 8'h00;
      lshift_q   <= 1'b0;
      rshift_q   <= 1'b0;
      caps_q     <= 1'b0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      held_q   <= held_d;
      lshift_q <= lshift_d;
      rshift_q <= rshift_d;
      caps_q   <= caps_d;
      if (accept) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (push && !accept) begin
        overflow_q <= 1'b1;
      end
    end
  end

  kbd_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (EntryW)
  ) u_fifo (
    .clk_i    (clk),
    .rst_i    (rst),
    .push_i   (push),
    .data_i   (push_data),
    .pop_i    (ev_ready),
    .accept_o (accept),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .head_o   (head)
  );

endmodule

// File: tb/tb_kbd_decoder.sv
// Self-checking bench: directed vector table, hand sequences and random bytes against a queue model.
module tb_kbd_decoder;

  localparam int Depth = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       scan_valid;
  logic [7:0] scan_code;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_scan;
  logic [7:0] ev_ascii;
  logic       shift_o;
  logic       caps_o;
  logic [7:0] press_cnt;
  logic       overflow;

  always #5 clk = ~clk;

  kbd_decoder #(
    .FIFO_DEPTH (Depth),
    .CNT_W      (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .scan_valid (scan_valid),
    .scan_code  (scan_code),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_scan    (ev_scan),
    .ev_ascii   (ev_ascii),
    .shift_o    (shift_o),
    .caps_o     (caps_o),
    .press_cnt  (press_cnt),
    .overflow   (overflow)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                    8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                    8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                    8'h35, 8'h1A};
  logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                   8'h3E, 8'h46};
  logic [7:0] pool [24] = '{8'h1C, 8'h32, 8'h21, 8'h1A, 8'h35, 8'h45, 8'h16, 8'h46, 8'h12,
                            8'h59, 8'h58, 8'hF0, 8'hF0, 8'hE0, 8'hFA, 8'hAA, 8'hE1, 8'h29,
                            8'h5A, 8'h66, 8'h77, 8'h75, 8'h12, 8'h1C};

  // Reference model state
  bit          m_brk, m_ext;
  logic [7:0]  m_held;
  bit          m_ls, m_rs, m_caps, m_ovf;
  logic [7:0]  m_cnt;
  logic [15:0] m_q [$];

  function automatic logic [7:0] ref_ascii(input logic [7:0] c, input bit upper);
    for (int i = 0; i < 26; i++) begin
      if (letter_codes[i] == c) return upper ? 8'(8'h41 + i) : 8'(8'h61 + i);
    end
    for (int i = 0; i < 10; i++) begin
      if (digit_codes[i] == c) return 8'(8'h30 + i);
    end
    if (c == 8'h29) return 8'h20;
    if (c == 8'h5A) return 8'h0D;
    if (c == 8'h66) return 8'h08;
    return 8'h00;
  endfunction

  task automatic model_reset();
    m_brk = 0; m_ext = 0; m_held = 8'h00; m_ls = 0; m_rs = 0; m_caps = 0;
    m_ovf = 0; m_cnt = 8'h00; m_q.delete();
  endtask

  task automatic model_step(input bit v, input logic [7:0] c, input bit r);
    bit          do_pop, do_push, upper;
    logic [15:0] entry;
    do_pop  = r && (m_q.size() > 0);
    do_push = 0;
    entry   = 16'h0;
    upper   = (m_ls || m_rs) ^ m_caps;
    if (v) begin
      if (m_ext && m_brk) begin
        m_ext = 0; m_brk = 0;
      end else if (m_ext) begin
        if (c == 8'hF0) m_brk = 1;
        else m_ext = 0;
      end else if (m_brk) begin
        m_brk = 0;
        if (c == 8'h12) m_ls = 0;
        if (c == 8'h59) m_rs = 0;
        if (c == m_held) m_held = 8'h00;
      end else if (c == 8'hF0) begin
        m_brk = 1;
      end else if (c == 8'hE0) begin
        m_ext = 1;
      end else if (c != 8'hFA && c != 8'hAA && c != 8'hE1 && c != m_held) begin
        m_held = c;
        if (c == 8'h12) m_ls = 1;
        else if (c == 8'h59) m_rs = 1;
        else if (c == 8'h58) m_caps = !m_caps;
        else begin
          do_push = 1;
          entry   = {c, ref_ascii(c, upper)};
        end
      end
    end
    if (do_pop) void'(m_q.pop_front());
    if (do_push) begin
      if (m_q.size() < Depth) begin
        m_q.push_back(entry);
        m_cnt = m_cnt + 8'd1;
      end else begin
        m_ovf = 1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("ev_valid", 32'(ev_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      chk("ev_scan", 32'(ev_scan), 32'(m_q[0][15:8]));
      chk("ev_ascii", 32'(ev_ascii), 32'(m_q[0][7:0]));
    end
    chk("shift_o", 32'(shift_o), 32'(m_ls || m_rs));
    chk("caps_o", 32'(caps_o), 32'(m_caps));
    chk("press_cnt", 32'(press_cnt), 32'(m_cnt));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic cycle(input bit v, input logic [7:0] c, input bit r);
    scan_valid = v;
    scan_code  = c;
    ev_ready   = r;
    model_step(v, c, r);
    @(posedge clk);
    #1;
    scan_valid = 1'b0;
    check_model();
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    scan_valid = 1'b0;
    scan_code  = 8'h00;
    ev_ready   = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
    chk("rst_ev_valid", 32'(ev_valid), 32'd0);
    chk("rst_ev_scan", 32'(ev_scan), 32'd0);
    chk("rst_ev_ascii", 32'(ev_ascii), 32'd0);
    chk("rst_shift", 32'(shift_o), 32'd0);
    chk("rst_caps", 32'(caps_o), 32'd0);
    chk("rst_cnt", 32'(press_cnt), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
  endtask

  typedef struct {
    logic [7:0] code;
    logic       exp_valid;
    logic [7:0] exp_scan;
    logic [7:0] exp_ascii;
    logic       exp_shift;
    logic       exp_caps;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs [$];

  initial begin
    logic [7:0] exp_heads [8];
    logic [7:0] exp_rep [3];

    vecs.push_back('{8'h1C, 1'b1, 8'h1C, 8'h61, 1'b0, 1'b0, 8'd1});
    vecs.push_back('{8'hF0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'd1});
    vecs.push_back('{8'h1C, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'd1});
    vecs.push_back('{8'h12, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'd1});
    vecs.push_back('{8'h1C, 1'b1, 8'h1C, 8'h41, 1'b1, 1'b0, 8'd2});
    vecs.push_back('{8'hF0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'd2});
    vecs.push_back('{8'h1C, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'd2});
    vecs.push_back('{8'hF0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'd2});
    vecs.push_back('{8'h12, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'd2});
    vecs.push_back('{8'h58, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'd2});
    vecs.push_back('{8'hF0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'd2});
    vecs.push_back('{8'h58, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'd2});
    vecs.push_back('{8'h12, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'd2});
    vecs.push_back('{8'h1C, 1'b1, 8'h1C, 8'h61, 1'b1, 1'b1, 8'd3});
    vecs.push_back('{8'hF0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'd3});
    vecs.push_back('{8'h1C, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'd3});
    vecs.push_back('{8'hF0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'd3});
    vecs.push_back('{8'h12, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'd3});
    vecs.push_back('{8'h58, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'd3});
    vecs.push_back('{8'hF0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'd3});
    vecs.push_back('{8'h58, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'd3});

    do_reset();

    // Directed table with the consumer always ready
    foreach (vecs[i]) begin
      cycle(1'b1, vecs[i].code, 1'b1);
      chk($sformatf("vec%0d_valid", i), 32'(ev_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        chk($sformatf("vec%0d_scan", i), 32'(ev_scan), 32'(vecs[i].exp_scan));
        chk($sformatf("vec%0d_ascii", i), 32'(ev_ascii), 32'(vecs[i].exp_ascii));
      end
      chk($sformatf("vec%0d_shift", i), 32'(shift_o), 32'(vecs[i].exp_shift));
      chk($sformatf("vec%0d_caps", i), 32'(caps_o), 32'(vecs[i].exp_caps));
      chk($sformatf("vec%0d_cnt", i), 32'(press_cnt), 32'(vecs[i].exp_cnt));
    end

    // Typematic repeats and extended keys
    do_reset();
    cycle(1'b1, 8'h1C, 1'b0);
    cycle(1'b1, 8'h1C, 1'b0);
    cycle(1'b1, 8'h1C, 1'b0);
    cycle(1'b1, 8'hF0, 1'b0);
    cycle(1'b1, 8'h1C, 1'b0);
    cycle(1'b1, 8'h1C, 1'b0);
    chk("repeat_cnt", 32'(press_cnt), 32'd2);
    cycle(1'b1, 8'hE0, 1'b0);
    cycle(1'b1, 8'h75, 1'b0);
    cycle(1'b1, 8'hE0, 1'b0);
    cycle(1'b1, 8'hF0, 1'b0);
    cycle(1'b1, 8'h75, 1'b0);
    chk("ext_cnt", 32'(press_cnt), 32'd2);
    cycle(1'b1, 8'h1A, 1'b0);
    chk("post_ext_cnt", 32'(press_cnt), 32'd3);
    exp_rep[0] = 8'h1C; exp_rep[1] = 8'h1C; exp_rep[2] = 8'h1A;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("repeat_head%0d", k), 32'(ev_scan), 32'(exp_rep[k]));
      cycle(1'b0, 8'h00, 1'b1);
    end
    chk("repeat_drained", 32'(ev_valid), 32'd0);

    // Overflow, simultaneous push/pop while full, in-order drain
    do_reset();
    for (int k = 0; k < 9; k++) cycle(1'b1, letter_codes[k], 1'b0);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_cnt", 32'(press_cnt), 32'd8);
    chk("ovf_head", 32'(ev_scan), 32'(letter_codes[0]));
    cycle(1'b1, 8'h3B, 1'b1);
    chk("full_pushpop_cnt", 32'(press_cnt), 32'd9);
    for (int k = 0; k < 7; k++) exp_heads[k] = letter_codes[k + 1];
    exp_heads[7] = 8'h3B;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain_head%0d", k), 32'(ev_scan), 32'(exp_heads[k]));
      cycle(1'b0, 8'h00, 1'b1);
    end
    chk("drain_empty", 32'(ev_valid), 32'd0);
    cycle(1'b0, 8'h00, 1'b1);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Reset between break prefix and break byte
    do_reset();
    cycle(1'b1, 8'hF0, 1'b1);
    do_reset();
    cycle(1'b1, 8'h1C, 1'b1);
    chk("rst_mid_valid", 32'(ev_valid), 32'd1);
    chk("rst_mid_scan", 32'(ev_scan), 32'h1C);
    chk("rst_mid_cnt", 32'(press_cnt), 32'd1);

    // Random bytes against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 9) < 6), pool[$urandom_range(0, 23)],
            ($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
